// File: rtl/bsg_manycore_dram_req_issue_if.sv
// rtl/bsg_manycore_dram_req_issue_if.sv - request-in / launch-out bundle of the DRAM request issue stage
// slave: the issue stage; master: the tile endpoint on the request side and the launcher on the head side
interface bsg_manycore_dram_req_issue_if #(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7
);
  logic                      v_i;
  logic [data_width_p-1:0]   eva_i;
  logic [data_width_p-1:0]   data_i;
  logic [data_width_p/8-1:0] mask_i;
  logic                      we_i;
  logic                      ready_o;

  logic                      v_o;
  logic [x_cord_width_p-1:0] x_cord_o;
  logic [y_cord_width_p-1:0] y_cord_o;
  logic [addr_width_p-1:0]   epa_o;
  logic [data_width_p-1:0]   data_o;
  logic [data_width_p/8-1:0] mask_o;
  logic                      we_o;
  logic                      yumi_i;

  modport slave (
    input  v_i, eva_i, data_i, mask_i, we_i, yumi_i,
    output ready_o, v_o, x_cord_o, y_cord_o, epa_o, data_o, mask_o, we_o
  );

  modport master (
    output v_i, eva_i, data_i, mask_i, we_i, yumi_i,
    input  ready_o, v_o, x_cord_o, y_cord_o, epa_o, data_o, mask_o, we_o
  );
endinterface

// File: rtl/bsg_manycore_dram_req_issue.sv
// rtl/bsg_manycore_dram_req_issue.sv - DRAM hash at accept, 2-entry in-order queue, outstanding-credit cap
// BSG_MANYCORE_DRAM_REQ_STATS_EN adds stat_issued_o / stat_stall_o counters
module bsg_manycore_dram_req_issue #(
  parameter int data_width_p                 = 32,
  parameter int addr_width_p                 = 28,
  parameter int x_cord_width_p               = 7,
  parameter int y_cord_width_p               = 7,
  parameter int pod_x_cord_width_p           = 3,
  parameter int pod_y_cord_width_p           = 4,
  parameter int x_subcord_width_p            = 4,
  parameter int y_subcord_width_p            = 3,
  parameter int num_vcache_rows_p            = 1,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int max_out_credits_p            = 32,
  localparam int credit_width_lp             = $clog2(max_out_credits_p+1)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [pod_x_cord_width_p-1:0] pod_x_i,
  input  logic [pod_y_cord_width_p-1:0] pod_y_i,
  bsg_manycore_dram_req_issue_if.slave  req_if,
  input  logic                          credit_return_i,
  output logic [credit_width_lp-1:0]    credits_o,
  output logic                          idle_o
`ifdef BSG_MANYCORE_DRAM_REQ_STATS_EN
  ,
  output logic [31:0]                   stat_issued_o,
  output logic [31:0]                   stat_stall_o
`endif
);
  localparam int blk_lp      = $clog2(vcache_block_size_in_words_p);
  localparam int row_lp      = $clog2(2*num_vcache_rows_p);
  localparam int xsub_lsb_lp = 2 + blk_lp;
  localparam int row_lsb_lp  = xsub_lsb_lp + x_subcord_width_p;
  localparam int idx_lsb_lp  = row_lsb_lp + row_lp;
  localparam int idx_w_lp    = addr_width_p - 1 - blk_lp;
  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  typedef struct packed {
    logic [x_cord_width_p-1:0] x;
    logic [y_cord_width_p-1:0] y;
    logic [addr_width_p-1:0]   epa;
    logic [data_width_p-1:0]   data;
    logic [data_width_p/8-1:0] mask;
    logic                      we;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} q_state_e;

  q_state_e                     r_state, w_state_nxt;
  logic                         w_not_full, w_not_empty;
  entry_t                       r_mem [2];
  logic                         r_wr_ptr, r_rd_ptr;
  logic [credit_width_lp-1:0]   r_credits;
  logic                         w_enq, w_deq;
  entry_t                       w_entry, w_head;

  // Hash: word offset | x subcord | row id | index, with the EVA MSB dropped
  logic [x_subcord_width_p-1:0]  w_x_sub;
  logic [row_lp-1:0]             w_row_id, w_row_num;
  logic                          w_south;
  logic [y_subcord_width_p-1:0]  w_y_sub;
  logic [pod_y_cord_width_p-1:0] w_pod_y_dst;
  logic [data_width_p-1:0]       w_eva_nomsb, w_idx_full;
  logic                          w_unused;

  assign w_x_sub     = req_if.eva_i[xsub_lsb_lp +: x_subcord_width_p];
  assign w_row_id    = req_if.eva_i[row_lsb_lp +: row_lp];
  assign w_south     = w_row_id[0];
  assign w_row_num   = w_row_id >> 1;
  // South pod's vcache rows count down from the top edge, north pod's up from the bottom edge
  assign w_y_sub     = w_south ? y_subcord_width_p'(w_row_num) : ~y_subcord_width_p'(w_row_num);
  assign w_pod_y_dst = w_south ? pod_y_i + pod_y_cord_width_p'(1) : pod_y_i - pod_y_cord_width_p'(1);
  assign w_eva_nomsb = {1'b0, req_if.eva_i[data_width_p-2:0]};
  assign w_idx_full  = w_eva_nomsb >> idx_lsb_lp;
  assign w_unused    = ^{req_if.eva_i[data_width_p-1], w_idx_full[data_width_p-1:idx_w_lp]};

  assign w_entry.x    = {pod_x_i, w_x_sub};
  assign w_entry.y    = {w_pod_y_dst, w_y_sub};
  assign w_entry.epa  = {1'b0, w_idx_full[idx_w_lp-1:0], req_if.eva_i[2 +: blk_lp]};
  assign w_entry.data = req_if.data_i;
  assign w_entry.mask = req_if.mask_i;
  assign w_entry.we   = req_if.we_i;

  always_comb begin
    w_state_nxt = r_state;
    w_not_full  = 1'b1;
    w_not_empty = 1'b0;
    case (r_state)
      S_EMPTY: if (w_enq) w_state_nxt = S_ONE;
      S_ONE: begin
        w_not_empty = 1'b1;
        if (w_enq && !w_deq) w_state_nxt = S_FULL;
        else if (w_deq && !w_enq) w_state_nxt = S_EMPTY;
      end
      S_FULL: begin
        w_not_full  = 1'b0;
        w_not_empty = 1'b1;
        if (w_deq) w_state_nxt = S_ONE;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  assign req_if.ready_o = reset_n_i & w_not_full & (r_credits != '0);
  assign req_if.v_o     = reset_n_i & w_not_empty;
  assign w_enq          = req_if.v_i & req_if.ready_o;
  assign w_deq          = req_if.yumi_i & req_if.v_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state  <= S_EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enq) r_wr_ptr <= ~r_wr_ptr;
      if (w_deq) r_rd_ptr <= ~r_rd_ptr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign req_if.x_cord_o = w_head.x;
  assign req_if.y_cord_o = w_head.y;
  assign req_if.epa_o    = w_head.epa;
  assign req_if.data_o   = w_head.data;
  assign req_if.mask_o   = w_head.mask;
  assign req_if.we_o     = w_head.we;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_credits <= max_credits_lp;
    end else if (w_enq && !credit_return_i) begin
      r_credits <= r_credits - credit_width_lp'(1);
    end else if (!w_enq && credit_return_i && r_credits != max_credits_lp) begin
      r_credits <= r_credits + credit_width_lp'(1);
    end
  end

  assign credits_o = r_credits;
  assign idle_o    = reset_n_i & ~w_not_empty & (r_credits == max_credits_lp);

`ifdef BSG_MANYCORE_DRAM_REQ_STATS_EN
  logic [31:0] r_stat_issued, r_stat_stall;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_deq) r_stat_issued <= r_stat_issued + 32'd1;
      if (req_if.v_i && !req_if.ready_o) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end
  assign stat_issued_o = r_stat_issued;
  assign stat_stall_o  = r_stat_stall;
`endif

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(req_if.yumi_i && !req_if.v_o))
    else $error("dram_req_issue: yumi_i asserted while v_o=0");

  a_credit_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(credit_return_i && !w_enq && r_credits == max_credits_lp))
    else $error("dram_req_issue: credit returned with all credits already available");
endmodule
